// File: rtl/risc8_pkg.sv
// risc8_pkg: opcodes, the ALU-none select code and the sequencer state encoding,
// shared by the sequencer and its testbench-visible behaviour.
package risc8_pkg;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_JMP   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] ALU_NONE = 4'b1111;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;
  function automatic logic is_alu(input logic [3:0] op);
    return !op[3];
  endfunction
endpackage

// File: rtl/contor_pc.sv
// contor_pc: 8-bit program counter with load priority over increment, wrapping at 0xFF.
module contor_pc (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] pc
);
  logic [7:0] r_pc;
  always_ff @(posedge clk) begin
    if (rst) r_pc <= '0;
    else if (load) r_pc <= load_val;
    else if (inc) r_pc <= r_pc + 8'd1;
  end
  assign pc = r_pc;
endmodule

// File: rtl/secventiator.sv
// secventiator: fetch/decode/execute sequencer for the risc8 core.
// Define ILLEGAL_TRAP_EN to trap opcodes 1100-1110 instead of retiring them as NOPs.
module secventiator
  import risc8_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [15:0] instr,
  output logic [7:0]  pc,
  output logic [15:0] ir,
  output logic [3:0]  alu_ctrl,
  output logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        zero_flag,
  output logic        busy,
  output logic        halted,
  output logic [15:0] retired
);
`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DST = S_TRAP;
`else
  localparam state_t ILLEGAL_DST = S_FETCH;
`endif
  state_t      r_state, w_nxt;
  logic [15:0] r_ir, r_retired;
  logic [3:0]  r_alu_ctrl, w_op;
  logic        r_imem_req, r_dmem_req, r_dmem_we, r_reg_write, r_busy, r_halted;
  logic        w_fetched, w_take, w_retire;
  assign w_op      = r_ir[15:12];
  assign w_fetched = r_state == S_FETCH && imem_ready;
  assign w_take    = r_state == S_DECODE && (w_op == OP_JMP || (w_op == OP_BEQ && zero_flag));
  assign w_retire  = r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB} && w_nxt inside {S_FETCH, S_HALT};
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_nxt = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: w_nxt = (is_alu(w_op) || w_op == OP_BEQ || w_op == OP_JMP) ? S_EXEC :
                        (w_op == OP_LOAD || w_op == OP_STORE) ? S_MEM :
                        w_op == OP_HALT ? S_HALT : ILLEGAL_DST;
      S_EXEC:   w_nxt = is_alu(w_op) ? S_WB : S_FETCH;
      S_MEM:    w_nxt = !dmem_ready ? S_MEM : w_op == OP_LOAD ? S_WB : S_FETCH;
      S_WB:     w_nxt = S_FETCH;
      default:  w_nxt = r_state;
    endcase
  end
  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_retired   <= '0;
      r_imem_req  <= 1'b0;
      r_dmem_req  <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_ctrl  <= ALU_NONE;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      if (w_fetched) r_ir <= instr;
      if (w_retire) r_retired <= r_retired + 16'd1;
      r_imem_req  <= w_nxt == S_FETCH;
      r_dmem_req  <= w_nxt == S_MEM;
      r_dmem_we   <= w_nxt == S_MEM && w_op == OP_STORE;
      r_reg_write <= w_nxt == S_WB;
      r_alu_ctrl  <= (w_nxt == S_EXEC || w_nxt == S_WB) && is_alu(w_op) ? w_op : ALU_NONE;
      r_busy      <= !(w_nxt inside {S_IDLE, S_HALT, S_TRAP});
      r_halted    <= w_nxt == S_HALT || w_nxt == S_TRAP;
    end
  end
  contor_pc u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_fetched),
    .load     (w_take),
    .load_val (r_ir[7:0]),
    .pc       (pc)
  );
  assign imem_req  = r_imem_req;
  assign ir        = r_ir;
  assign alu_ctrl  = r_alu_ctrl;
  assign reg_write = r_reg_write;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign retired   = r_retired;
endmodule

// File: tb/tb_secventiator.sv
// tb_secventiator: directed and randomized checks of the sequencer against an
// instruction-level model (next pc, retire count, latency, strobe counts).
module tb_secventiator;
  logic        clk = 1'b0;
  logic        rst, start, imem_ready, dmem_ready, zero_flag;
  logic [15:0] instr;
  logic        imem_req, reg_write, dmem_req, dmem_we, busy, halted;
  logic [7:0]  pc;
  logic [15:0] ir, retired;
  logic [3:0]  alu_ctrl;
  int          errs = 0, checks = 0;
  logic [7:0]  m_pc;
  logic [15:0] m_ret;

  secventiator dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ready(imem_ready),
    .instr(instr), .pc(pc), .ir(ir), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .zero_flag(zero_flag),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from a FETCH observation to the next FETCH observation.
  task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input logic z);
    logic [3:0] op;
    int lat, n_rw, n_dr, n_dw, n_alu, n_aluop, dc, base;
    logic is_a, is_ld, is_st, taken;
    op = ins[15:12];
    chk("fetch_req", imem_req, 1);
    chk("fetch_pc", pc, m_pc);
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0;
      instr = 16'($urandom);
      dmem_ready = 1'($urandom);
      step();
      chk("imem_hold", imem_req, 1);
    end
    imem_ready = 1'b1;
    instr = ins;
    zero_flag = z;
    dmem_ready = 1'($urandom);
    lat = 0; n_rw = 0; n_dr = 0; n_dw = 0; n_alu = 0; n_aluop = 0; dc = 0;
    while (lat < 40) begin
      step();
      lat++;
      if (imem_req === 1'b1) begin
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        break;
      end
      n_rw += int'(reg_write === 1'b1);
      n_dr += int'(dmem_req === 1'b1);
      n_dw += int'(dmem_we === 1'b1);
      n_alu += int'(alu_ctrl !== 4'hF);
      n_aluop += int'(alu_ctrl === op);
      imem_ready = 1'($urandom);
      instr = 16'($urandom);
      dmem_ready = dmem_req ? (dc == dw) : 1'($urandom);
      if (dmem_req) dc++;
    end
    is_a  = op < 4'd8;
    is_ld = op == 4'd8;
    is_st = op == 4'd9;
    taken = op == 4'hB || (op == 4'hA && z);
    base  = (is_a || is_ld) ? 4 : (is_st || op == 4'hA || op == 4'hB) ? 3 : 2;
    m_pc  = taken ? ins[7:0] : m_pc + 8'd1;
    m_ret = m_ret + 16'd1;
    chk("latency", lat, base + ((is_ld || is_st) ? dw : 0));
    chk("next_pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("ir", ir, ins);
    chk("reg_write_cnt", n_rw, (is_a || is_ld) ? 1 : 0);
    chk("dmem_req_cnt", n_dr, (is_ld || is_st) ? dw + 1 : 0);
    chk("dmem_we_cnt", n_dw, is_st ? dw + 1 : 0);
    chk("alu_active_cnt", n_alu, is_a ? 2 : 0);
    chk("alu_op_cnt", n_aluop, is_a ? 2 : 0);
  endtask

  initial begin
    logic [3:0] rop;
    rst = 1'b1; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero_flag = 1'b0; instr = 16'hFFFF;
    step(); step();
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_alu", alu_ctrl, 4'hF);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    step();
    chk("idle_stays", imem_req, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    m_pc = 8'h00; m_ret = 16'h0000;
    run_instr(16'h0000, 0, 0, 1'b0);
    run_instr(16'h8012, 1, 3, 1'b0);
    run_instr(16'hB0FF, 0, 0, 1'b0);
    run_instr(16'h1234, 2, 0, 1'b0);
    run_instr(16'hB0B0, 0, 0, 1'b0);
    run_instr(16'hA020, 0, 0, 1'b0);
    run_instr(16'hA020, 0, 0, 1'b1);
    run_instr(16'h9033, 0, 2, 1'b0);
    for (int k = 0; k < 150; k++) begin
      rop = 4'($urandom_range(0, 11));
      run_instr({rop, 4'($urandom), 8'($urandom)}, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 1'($urandom));
    end
`ifdef ILLEGAL_TRAP_EN
    imem_ready = 1'b1; instr = 16'hC000;
    step();
    imem_ready = 1'b0;
    step(); step();
    chk("trap_halted", halted, 1);
    chk("trap_busy", busy, 0);
    chk("trap_pc", pc, m_pc + 8'd1);
    chk("trap_retired", retired, m_ret);
    start = 1'b1; imem_ready = 1'b1;
    step(); step();
    start = 1'b0; imem_ready = 1'b0;
    chk("trap_sticky", halted, 1);
    chk("trap_no_fetch", imem_req, 0);
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    m_pc = 8'h00; m_ret = 16'h0000;
`else
    run_instr(16'hC0AA, 0, 0, 1'b0);
`endif
    chk("pre_halt_req", imem_req, 1);
    imem_ready = 1'b1; instr = 16'hF000;
    step();
    imem_ready = 1'b0;
    step(); step();
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_retired", retired, m_ret + 16'd1);
    chk("halt_pc", pc, m_pc + 8'd1);
    start = 1'b1; imem_ready = 1'b1;
    step(); step();
    start = 1'b0; imem_ready = 1'b0;
    chk("halt_start_ignored", halted, 1);
    chk("halt_no_fetch", imem_req, 0);
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("rst2_fetch", imem_req, 1);
    imem_ready = 1'b1; instr = 16'h1234; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_req", imem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ir", ir, 16'h0000);
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_retired", retired, 16'h0000);
    step(); step();
    chk("idle_ready_ignored_ir", ir, 16'h0000);
    chk("idle_ready_ignored_pc", pc, 8'h00);
    imem_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
